// File: rtl/wb_ram_slave_if.sv
// Wishbone B4 slave-side bundle for wb_ram_slave: the request inputs from
// the bus master and the data/ack/err responses from the slave.
interface wb_ram_slave_if #(
  parameter int aw = 32
);
  logic [aw-1:0] wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone slave front-end for a synchronous-read RAM, with classic and
// incrementing/wrapping bursts. Define WB_RAM_SLAVE_ERR_EN to error out-of-range addresses.
module wb_ram_slave #(
  parameter int depth = 256,
  parameter int aw    = 32
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  wb_ram_slave_if.slave            wb,
  output logic [3:0]               ram_we,
  output logic [31:0]              ram_din,
  output logic [$clog2(depth)-1:0] ram_waddr,
  output logic [$clog2(depth)-1:0] ram_raddr,
  input  logic [31:0]              ram_dout
);

  localparam int WW = $clog2(depth);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_ack;
  logic          r_err;
  logic          w_ack_nxt;
  logic          w_err_nxt;
  logic [WW-1:0] w_word;
  logic          w_req;
  logic          w_bad;
  logic          w_we_ok;
  logic          w_unused;

  function automatic logic [WW-1:0] next_addr(input logic [WW-1:0] a, input logic [1:0] bte);
    logic [WW-1:0] n;
    n = a;
    case (bte)
      2'b00:   n = a + {{(WW-1){1'b0}}, 1'b1};
      2'b01:   n[1:0] = a[1:0] + 2'd1;
      2'b10:   n[2:0] = a[2:0] + 3'd1;
      2'b11:   n[3:0] = a[3:0] + 4'd1;
      default: n = a;
    endcase
    return n;
  endfunction

  assign w_word   = wb.wb_adr_i[WW+1:2];
  assign w_req    = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_unused = ^{wb.wb_adr_i[1:0], wb.wb_adr_i[aw-1:WW+2]};

`ifdef WB_RAM_SLAVE_ERR_EN
  assign w_bad = |wb.wb_adr_i[aw-1:WW+2];
`else
  assign w_bad = 1'b0;
`endif

  // Writes are also gated by reset so a burst aborted by reset commits nothing more.
  assign w_we_ok = wb_rst_n_i & w_req & wb.wb_we_i & ~w_bad & ~r_err &
                   (~r_ack | (r_state == BURST));

  assign ram_we    = w_we_ok ? wb.wb_sel_i : 4'b0000;
  assign ram_din   = wb.wb_dat_i;
  assign ram_waddr = w_word;
  // In a running burst the current beat is already in flight, so prefetch the next one.
  assign ram_raddr = ((r_state == BURST) && w_req && r_ack) ? next_addr(w_word, wb.wb_bte_i) : w_word;

  assign wb.wb_dat_o = r_ack ? ram_dout : 32'h0000_0000;
  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;

  // Next-state and registered ack/err decisions.
  always_comb begin
    w_state_nxt = IDLE;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    if (!w_req) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_ack && !r_err) begin
            if (w_bad) begin
              w_err_nxt = 1'b1;
            end else begin
              w_ack_nxt   = 1'b1;
              w_state_nxt = (wb.wb_cti_i == 3'b010) ? BURST : IDLE;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
        BURST: begin
          if (w_bad) begin
            w_err_nxt = 1'b1;
          end else if (wb.wb_cti_i == 3'b010) begin
            w_ack_nxt   = 1'b1;
            w_state_nxt = BURST;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed, scoreboarded bench for wb_ram_slave with a byte-writable synchronous RAM model.
module tb_wb_ram_slave;
  localparam int DEPTH = 256;
  localparam int AW    = 32;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [7:0]  ram_waddr;
  logic [7:0]  ram_raddr;
  logic [31:0] mem [DEPTH];
  logic [31:0] exp_q [$];
  int          n_pass  = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  wb_ram_slave_if #(.aw(AW)) wb ();

  wb_ram_slave #(.depth(DEPTH), .aw(AW)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .wb        (wb),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_dout  (ram_dout)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
    end
    ram_dout <= mem[ram_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti,
                       input logic [1:0] bte);
    wb.wb_cyc_i = cyc;
    wb.wb_stb_i = stb;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = sel;
    wb.wb_cti_i = cti;
    wb.wb_bte_i = bte;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
  endtask

  // One bus cycle: sample mid-cycle, score read data on an accepted ack, then advance.
  task automatic clk_cycle(input string tag, input logic exp_ack, input logic exp_err, input logic chk_ack);
    logic [31:0] e;
    @(negedge clk);
    if (chk_ack) check({tag, "_ack"}, {31'd0, wb.wb_ack_o}, {31'd0, exp_ack});
    check({tag, "_err"}, {31'd0, wb.wb_err_o}, {31'd0, exp_err});
    check({tag, "_ack_err_excl"}, {31'd0, wb.wb_ack_o & wb.wb_err_o}, 32'd0);
    if (wb.wb_ack_o && wb.wb_cyc_i && wb.wb_stb_i && !wb.wb_we_i) begin
      check({tag, "_sb_nonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({tag, "_rdata"}, wb.wb_dat_o, e);
      end
    end else if (!wb.wb_ack_o) begin
      check({tag, "_dat_zero"}, wb.wb_dat_o, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_classic(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
    drive(1'b1, 1'b1, 1'b1, adr, dat, sel, 3'b000, 2'b00);
    clk_cycle({tag, "_n0"}, 1'b0, 1'b0, 1'b1);
    clk_cycle({tag, "_n1"}, 1'b1, 1'b0, 1'b1);
    idle();
    clk_cycle({tag, "_n2"}, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rd_classic(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    drive(1'b1, 1'b1, 1'b0, adr, 32'h0, 4'hF, 3'b000, 2'b00);
    exp_q.push_back(exp);
    clk_cycle({tag, "_n0"}, 1'b0, 1'b0, 1'b1);
    clk_cycle({tag, "_n1"}, 1'b1, 1'b0, 1'b1);
    idle();
    clk_cycle({tag, "_n2"}, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    idle();
    check("rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    check("rst_err", {31'd0, wb.wb_err_o}, 32'd0);
    check("rst_dat", wb.wb_dat_o, 32'd0);
    check("rst_we", {28'd0, ram_we}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Classic write, ack one cycle later, no write while ack is high.
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00);
    check("cw_we", {28'd0, ram_we}, 32'h0000_000F);
    check("cw_waddr", {24'd0, ram_waddr}, 32'd4);
    clk_cycle("cw_n0", 1'b0, 1'b0, 1'b1);
    check("cw_we_acked", {28'd0, ram_we}, 32'd0);
    clk_cycle("cw_n1", 1'b1, 1'b0, 1'b1);
    idle();
    clk_cycle("cw_n2", 1'b0, 1'b0, 1'b1);
    check("cw_mem", mem[4], 32'hDEAD_BEEF);

    // Classic read with req held: two transfers, 2 cycles each.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 3'b000, 2'b00);
    check("cr_raddr", {24'd0, ram_raddr}, 32'd4);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    clk_cycle("cr_n0", 1'b0, 1'b0, 1'b1);
    clk_cycle("cr_n1", 1'b1, 1'b0, 1'b1);
    clk_cycle("cr_n2", 1'b0, 1'b0, 1'b1);
    clk_cycle("cr_n3", 1'b1, 1'b0, 1'b1);
    idle();
    clk_cycle("cr_n4", 1'b0, 1'b0, 1'b1);

    // Byte-lane write over existing data.
    wr_classic("bw", 32'h0000_0010, 32'h0000_AA00, 4'b0010);
    rd_classic("bw_rd", 32'h0000_0010, 32'hDEAD_AAEF);

    // Preload words 8..11 with 1..4.
    for (int i = 0; i < 4; i++) begin
      wr_classic("pre", 32'h0000_0020 + 32'(4 * i), 32'(i + 1), 4'hF);
    end

    // Linear 4-beat read burst.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 3'b010, 2'b00);
    exp_q.push_back(32'd1);
    clk_cycle("lb_n0", 1'b0, 1'b0, 1'b1);
    check("lb_prefetch", {24'd0, ram_raddr}, 32'd9);
    clk_cycle("lb_b0", 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0024, 32'h0, 4'hF, 3'b010, 2'b00);
    exp_q.push_back(32'd2);
    clk_cycle("lb_b1", 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0028, 32'h0, 4'hF, 3'b010, 2'b00);
    exp_q.push_back(32'd3);
    clk_cycle("lb_b2", 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_002C, 32'h0, 4'hF, 3'b111, 2'b00);
    exp_q.push_back(32'd4);
    clk_cycle("lb_b3", 1'b1, 1'b0, 1'b1);
    idle();
    clk_cycle("lb_end", 1'b0, 1'b0, 1'b1);

    // Wrap-4 burst from word 10, wait state after beat 2, then restart at word 8.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0028, 32'h0, 4'hF, 3'b010, 2'b01);
    exp_q.push_back(32'd3);
    clk_cycle("wb_n0", 1'b0, 1'b0, 1'b1);
    check("wb_prefetch11", {24'd0, ram_raddr}, 32'd11);
    clk_cycle("wb_b0", 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_002C, 32'h0, 4'hF, 3'b010, 2'b01);
    check("wb_prefetch8", {24'd0, ram_raddr}, 32'd8);
    exp_q.push_back(32'd4);
    clk_cycle("wb_b1", 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 3'b010, 2'b01);
    clk_cycle("wb_wait", 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 3'b111, 2'b01);
    check("wb_restart_raddr", {24'd0, ram_raddr}, 32'd8);
    exp_q.push_back(32'd1);
    clk_cycle("wb_restart", 1'b0, 1'b0, 1'b1);
    clk_cycle("wb_r_b0", 1'b1, 1'b0, 1'b1);
    idle();
    clk_cycle("wb_end", 1'b0, 1'b0, 1'b1);

    // Out-of-range address: error response or aliasing to word 0.
    wr_classic("w0", 32'h0000_0000, 32'hA5A5_A5A5, 4'hF);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF, 3'b000, 2'b00);
`ifdef WB_RAM_SLAVE_ERR_EN
    check("oor_we", {28'd0, ram_we}, 32'd0);
    clk_cycle("oor_n0", 1'b0, 1'b0, 1'b1);
    clk_cycle("oor_n1", 1'b0, 1'b1, 1'b1);
    idle();
    clk_cycle("oor_n2", 1'b0, 1'b0, 1'b1);
    check("oor_mem0", mem[0], 32'hA5A5_A5A5);
`else
    check("oor_we", {28'd0, ram_we}, 32'h0000_000F);
    check("oor_waddr", {24'd0, ram_waddr}, 32'd0);
    clk_cycle("oor_n0", 1'b0, 1'b0, 1'b1);
    clk_cycle("oor_n1", 1'b1, 1'b0, 1'b1);
    idle();
    clk_cycle("oor_n2", 1'b0, 1'b0, 1'b1);
    check("oor_mem0", mem[0], 32'h1234_5678);
`endif

    // Reset asserted during beat 2 of a write burst.
    wr_classic("pre13", 32'h0000_0034, 32'h0, 4'hF);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'h0000_0111, 4'hF, 3'b010, 2'b00);
    clk_cycle("rb_n0", 1'b0, 1'b0, 1'b1);
    clk_cycle("rb_b0", 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0034, 32'h0000_0222, 4'hF, 3'b010, 2'b00);
    rst_n = 1'b0;
    #1;
    check("rb_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    check("rb_we", {28'd0, ram_we}, 32'd0);
    idle();
    check("rb_dat", wb.wb_dat_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rb_mem12", mem[12], 32'h0000_0111);
    check("rb_mem13", mem[13], 32'h0000_0000);
    rd_classic("rb_rd", 32'h0000_0030, 32'h0000_0111);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
